// File: rtl/trap_seq_ctrl_pkg.sv
// Shared definitions for the machine-mode trap / MRET sequencer:
// FSM state encoding, interrupt cause codes and mtvec mode constants.
package trap_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_TRAP  = 3'd3,
        ST_RET   = 3'd4
    } state_e;

    localparam logic [4:0] CAUSE_MEI      = 5'd11;
    localparam logic [4:0] CAUSE_MTI      = 5'd7;
    localparam int         MCAUSE_INT_BIT = 31;
    localparam logic [1:0] MTVEC_MODE_VEC = 2'b01;

    // Byte offset of a vectored handler entry: one 4-byte slot per cause code.
    function automatic logic [6:0] vec_offset(input logic [4:0] code);
        return {code, 2'b00};
    endfunction

endpackage

// File: rtl/trap_seq_ctrl_cause_sel.sv
// Interrupt cause priority encoder: external interrupt beats timer interrupt.
// Purely combinational. o_valid is set when any enabled interrupt is pending.
module trap_cause_sel
    import trap_seq_ctrl_pkg::*;
(
    input  logic       i_meip,
    input  logic       i_meie,
    input  logic       i_mtip,
    input  logic       i_mtie,
    output logic       o_valid,
    output logic [4:0] o_code
);

    // Fixed priority select of the highest enabled pending interrupt.
    always_comb begin
        o_valid = 1'b0;
        o_code  = '0;
        if (i_meip && i_meie) begin
            o_valid = 1'b1;
            o_code  = CAUSE_MEI;
        end else if (i_mtip && i_mtie) begin
            o_valid = 1'b1;
            o_code  = CAUSE_MTI;
        end
    end

endmodule

// File: rtl/trap_seq_ctrl.sv
// Machine-mode interrupt entry and MRET sequencer for the 5-stage core.
// Optional build macro: TRAP_VECTORED_EN (vectored mtvec mode support).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting; MRET or an enabled pending interrupt starts a sequence
// FLUSH | first flush cycle of a committed trap, fetch held
// DRAIN | fetch held, flushes continue while EX/MEM/WB retire
// TRAP  | write mepc/mcause/mstatus, redirect PC to the trap vector
// RET   | MRET: restore MIE, redirect PC to mepc
//
// Every output is decoded from registered state only; targets and write data
// are captured into registers before the cycle that presents them.
module trap_seq_ctrl
    import trap_seq_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int DRAIN_CYCLES = 3
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            meip,
    input  logic            mtip,
    input  logic            mstatus_mie,
    input  logic            meie,
    input  logic            mtie,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc_in,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCF,
    input  logic            pcd_valid,
    input  logic            StallD,
    input  logic            mret_E,
    output logic            Int_flush,
    output logic            stall_F,
    output logic            pc_redirect,
    output logic [XLEN-1:0] pc_target,
    output logic            mepc_we,
    output logic [XLEN-1:0] mepc_wdata,
    output logic            mcause_we,
    output logic [XLEN-1:0] mcause_wdata,
    output logic            mstatus_trap,
    output logic            mstatus_mret,
    output logic            busy
);

    localparam logic [2:0] CNT_LOAD = 3'(DRAIN_CYCLES - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [2:0]        r_cnt;
    logic [4:0]        r_code;
    logic [XLEN-1:0]   r_epc;
    logic [XLEN-1:0]   r_target;

    logic              w_irq_valid;
    logic [4:0]        w_irq_code;
    logic              w_take;
    logic [XLEN-1:0]   w_vec_base;
    logic [XLEN-1:0]   w_vec_target;
    logic [XLEN-1:0]   w_mcause;

    trap_cause_sel u_cause_sel (
        .i_meip  (meip),
        .i_meie  (meie),
        .i_mtip  (mtip),
        .i_mtie  (mtie),
        .o_valid (w_irq_valid),
        .o_code  (w_irq_code)
    );

    assign w_take = mstatus_mie & w_irq_valid & ~StallD;

    // Trap vector address for the captured cause.
    always_comb begin
        w_vec_base   = {mtvec[XLEN-1:2], 2'b00};
        w_vec_target = w_vec_base;
`ifdef TRAP_VECTORED_EN
        if (mtvec[1:0] == MTVEC_MODE_VEC) begin
            w_vec_target = w_vec_base + XLEN'(vec_offset(r_code));
        end
`endif
    end

`ifndef TRAP_VECTORED_EN
    // The mode field only matters in the vectored build.
    logic w_unused_mode;
    assign w_unused_mode = ^mtvec[1:0];
`endif

    // mcause value: interrupt flag plus exception code.
    always_comb begin
        w_mcause                 = '0;
        w_mcause[MCAUSE_INT_BIT] = 1'b1;
        w_mcause[4:0]            = r_code;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Captured cause/epc/target and the drain down-counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_code   <= '0;
            r_epc    <= '0;
            r_target <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mret_E) begin
                        r_target <= mepc_in;
                    end else if (w_take) begin
                        r_code <= w_irq_code;
                        r_epc  <= pcd_valid ? PCD : PCF;
                    end
                end
                ST_FLUSH: begin
                    r_cnt <= CNT_LOAD;
                end
                ST_DRAIN: begin
                    if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else begin
                        r_target <= w_vec_target;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_state_nxt  = r_state;
        Int_flush    = 1'b0;
        stall_F      = 1'b0;
        pc_redirect  = 1'b0;
        pc_target    = '0;
        mepc_we      = 1'b0;
        mepc_wdata   = '0;
        mcause_we    = 1'b0;
        mcause_wdata = '0;
        mstatus_trap = 1'b0;
        mstatus_mret = 1'b0;
        busy         = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                // MRET takes precedence over a simultaneous interrupt.
                if (mret_E) begin
                    w_state_nxt = ST_RET;
                end else if (w_take) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                Int_flush   = 1'b1;
                stall_F     = 1'b1;
                w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                Int_flush = 1'b1;
                stall_F   = 1'b1;
                if (r_cnt == 3'd0) begin
                    w_state_nxt = ST_TRAP;
                end
            end
            ST_TRAP: begin
                Int_flush    = 1'b1;
                pc_redirect  = 1'b1;
                pc_target    = r_target;
                mepc_we      = 1'b1;
                mepc_wdata   = r_epc;
                mcause_we    = 1'b1;
                mcause_wdata = w_mcause;
                mstatus_trap = 1'b1;
                w_state_nxt  = ST_IDLE;
            end
            ST_RET: begin
                Int_flush    = 1'b1;
                pc_redirect  = 1'b1;
                pc_target    = r_target;
                mstatus_mret = 1'b1;
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_seq_ctrl.sv
// Self-checking bench for trap_seq_ctrl: directed scenarios followed by random
// stimulus, all checked cycle by cycle against a queue of expected output
// records scheduled by a transaction-level model.
module tb_trap_seq_ctrl;

    localparam int XLEN  = 32;
    localparam int DRAIN = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            meip, mtip, mstatus_mie, meie, mtie;
    logic [XLEN-1:0] mtvec, mepc_in, PCD, PCF;
    logic            pcd_valid, StallD, mret_E;
    logic            Int_flush, stall_F, pc_redirect;
    logic [XLEN-1:0] pc_target, mepc_wdata, mcause_wdata;
    logic            mepc_we, mcause_we, mstatus_trap, mstatus_mret, busy;

    trap_seq_ctrl #(.XLEN(XLEN), .DRAIN_CYCLES(DRAIN)) dut (
        .clk          (clk),
        .rst          (rst),
        .meip         (meip),
        .mtip         (mtip),
        .mstatus_mie  (mstatus_mie),
        .meie         (meie),
        .mtie         (mtie),
        .mtvec        (mtvec),
        .mepc_in      (mepc_in),
        .PCD          (PCD),
        .PCF          (PCF),
        .pcd_valid    (pcd_valid),
        .StallD       (StallD),
        .mret_E       (mret_E),
        .Int_flush    (Int_flush),
        .stall_F      (stall_F),
        .pc_redirect  (pc_redirect),
        .pc_target    (pc_target),
        .mepc_we      (mepc_we),
        .mepc_wdata   (mepc_wdata),
        .mcause_we    (mcause_we),
        .mcause_wdata (mcause_wdata),
        .mstatus_trap (mstatus_trap),
        .mstatus_mret (mstatus_mret),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        flush;
        logic        stall;
        logic        redir;
        logic [31:0] target;
        logic        mepc_we;
        logic [31:0] mepc_wd;
        logic        mcause_we;
        logic [31:0] mcause_wd;
        logic        trap;
        logic        mret;
        logic        busy;
    } rec_t;

    rec_t q[$];
    bit   m_idle;
    int   n_checks = 0;
    int   n_errors = 0;
    int   lat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare(input rec_t e);
        check("Int_flush",    32'(Int_flush),    32'(e.flush));
        check("stall_F",      32'(stall_F),      32'(e.stall));
        check("pc_redirect",  32'(pc_redirect),  32'(e.redir));
        check("pc_target",    pc_target,         e.target);
        check("mepc_we",      32'(mepc_we),      32'(e.mepc_we));
        check("mepc_wdata",   mepc_wdata,        e.mepc_wd);
        check("mcause_we",    32'(mcause_we),    32'(e.mcause_we));
        check("mcause_wdata", mcause_wdata,      e.mcause_wd);
        check("mstatus_trap", 32'(mstatus_trap), 32'(e.trap));
        check("mstatus_mret", 32'(mstatus_mret), 32'(e.mret));
        check("busy",         32'(busy),         32'(e.busy));
    endtask

    // When the controller is idle, turn the inputs it is about to sample into
    // the whole sequence of expected per-cycle outputs.
    task automatic model_decide();
        rec_t        r;
        int          code;
        logic [31:0] epc;
        logic [31:0] tgt;
        if (!m_idle) return;
        if (mret_E) begin
            r = '0;
            r.flush = 1; r.redir = 1; r.target = mepc_in; r.mret = 1; r.busy = 1;
            q.push_back(r);
            return;
        end
        if (!mstatus_mie || StallD) return;
        if (meip && meie)      code = 11;
        else if (mtip && mtie) code = 7;
        else return;
        epc = pcd_valid ? PCD : PCF;
        tgt = mtvec & ~32'h3;
`ifdef TRAP_VECTORED_EN
        if (mtvec[1:0] == 2'b01) tgt = tgt + 32'(code * 4);
`endif
        for (int i = 0; i < DRAIN + 1; i++) begin
            r = '0;
            r.flush = 1; r.stall = 1; r.busy = 1;
            q.push_back(r);
        end
        r = '0;
        r.flush = 1; r.redir = 1; r.target = tgt;
        r.mepc_we = 1; r.mepc_wd = epc;
        r.mcause_we = 1; r.mcause_wd = 32'h8000_0000 | 32'(code);
        r.trap = 1; r.busy = 1;
        q.push_back(r);
    endtask

    task automatic tick();
        rec_t e;
        model_decide();
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            e = '0;
            m_idle = 1;
        end else begin
            e = q.pop_front();
            m_idle = 0;
        end
        compare(e);
    endtask

    task automatic run_until_redirect(output int n);
        n = 0;
        while (!pc_redirect && n < 20) begin
            tick();
            n++;
        end
        if (!pc_redirect) check("redirect_timeout", 32'(pc_redirect), 32'd1);
    endtask

    task automatic clear_inputs();
        meip = 0; mtip = 0; mstatus_mie = 0; meie = 0; mtie = 0;
        mtvec = '0; mepc_in = '0; PCD = '0; PCF = '0;
        pcd_valid = 0; StallD = 0; mret_E = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0;
        clear_inputs();
        m_idle = 1;
        repeat (2) @(posedge clk);
        #1;
        compare('0);
        rst = 1'b1;

        // Timer interrupt, direct vector; pending drops once committed.
        mstatus_mie = 1; mtie = 1; mtip = 1;
        PCD = 32'h40; pcd_valid = 1; mtvec = 32'h100;
        tick();
        lat = 1;
        mtip = 0;
        run_until_redirect(n);
        lat += n;
        check("timer_latency", 32'(lat), 32'(DRAIN + 2));
        check("timer_mepc", mepc_wdata, 32'h40);
        check("timer_mcause", mcause_wdata, 32'h8000_0007);
        check("timer_target", pc_target, 32'h100);
        tick();

        // Simultaneous external and timer: external wins.
        meie = 1; mtie = 1; meip = 1; mtip = 1;
`ifdef TRAP_VECTORED_EN
        mtvec = 32'h101;
`else
        mtvec = 32'h100;
`endif
        tick();
        meip = 0; mtip = 0;
        run_until_redirect(n);
        check("both_mcause", mcause_wdata, 32'h8000_000B);
`ifdef TRAP_VECTORED_EN
        check("both_target", pc_target, 32'h12C);
`else
        check("both_target", pc_target, 32'h100);
`endif
        tick();

        // MRET collides with a pending interrupt; the IRQ is taken afterwards.
        mtvec = 32'h100; mepc_in = 32'h44; mret_E = 1; mtip = 1;
        tick();
        check("coll_ret_target", pc_target, 32'h44);
        check("coll_mret", 32'(mstatus_mret), 32'd1);
        check("coll_no_mcause", 32'(mcause_we), 32'd0);
        mret_E = 0;
        tick();
        tick();
        check("coll_irq_flush", 32'(stall_F), 32'd1);
        mtip = 0;
        run_until_redirect(n);
        tick();

        // Decode stall defers the interrupt.
        StallD = 1; mtip = 1;
        repeat (4) begin
            tick();
            check("stall_busy", 32'(busy), 32'd0);
        end
        StallD = 0;
        tick();
        check("stall_release_busy", 32'(busy), 32'd1);
        mtip = 0;
        run_until_redirect(n);
        tick();

        // Bubble in Decode: epc comes from PCF; pending drops during DRAIN.
        pcd_valid = 0; PCF = 32'h80; PCD = 32'h999; mtip = 1;
        tick();
        tick();
        mtip = 0;
        run_until_redirect(n);
        check("bubble_mepc", mepc_wdata, 32'h80);
        check("bubble_mcause", mcause_wdata, 32'h8000_0007);
        tick();

        // Reset in the middle of DRAIN.
        mtip = 1;
        tick();
        mtip = 0;
        tick();
        #2;
        rst = 1'b0;
        #1;
        q.delete();
        m_idle = 1;
        compare('0);
        @(posedge clk);
        #1;
        compare('0);
        rst = 1'b1;
        repeat (6) tick();

        // Random stimulus.
        for (int c = 0; c < 400; c++) begin
            meip        = ($urandom_range(0, 3) == 0);
            mtip        = ($urandom_range(0, 2) == 0);
            meie        = $urandom_range(0, 1) != 0;
            mtie        = $urandom_range(0, 1) != 0;
            mstatus_mie = ($urandom_range(0, 3) != 0);
            StallD      = ($urandom_range(0, 3) == 0);
            pcd_valid   = $urandom_range(0, 1) != 0;
            PCD         = $urandom & 32'hFFFF_FFFC;
            PCF         = $urandom & 32'hFFFF_FFFC;
            mret_E      = ($urandom_range(0, 7) == 0);
            if (m_idle) begin
                mtvec   = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
                mepc_in = $urandom & 32'hFFFF_FFFC;
            end
            tick();
        end

        clear_inputs();
        repeat (DRAIN + 4) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/trap_seq_ctrl.md
Name: trap_seq_ctrl

Overview:
- Machine-mode interrupt and MRET sequencer for the 5-stage core.
- Decides when a pending interrupt is taken and drives Int_flush into the IF/ID and ID/EX pipeline registers.
- Holds fetch while older instructions retire, writes mepc/mcause/mstatus through the CSR file, and redirects PC to the trap vector.
- Also sequences MRET: redirects PC to mepc and restores MIE.

Parameters:
- XLEN, 32, datapath/CSR width.
- DRAIN_CYCLES, 3, cycles fetch is held after flush so EX/MEM/WB instructions retire before CSR update (legal range 1..7).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-low reset (rst=0 resets)
- meip  in  1  external interrupt pending
- mtip  in  1  timer interrupt pending
- mstatus_mie  in  1  global interrupt enable
- meie  in  1  external enable (mie[11])
- mtie  in  1  timer enable (mie[7])
- mtvec  in  XLEN  trap vector CSR
- mepc_in  in  XLEN  current mepc CSR
- PCD  in  XLEN  PC of instruction in Decode
- PCF  in  XLEN  PC in Fetch
- pcd_valid  in  1  Decode holds a real instruction, not a bubble
- StallD  in  1  hazard-unit stall of Decode
- mret_E  in  1  MRET in Execute
- Int_flush  out  1  flush IF/ID and ID/EX
- stall_F  out  1  hold PC register
- pc_redirect  out  1  PC mux selects pc_target
- pc_target  out  XLEN  redirect address
- mepc_we  out  1  mepc write strobe
- mepc_wdata  out  XLEN  value for mepc
- mcause_we  out  1  mcause write strobe
- mcause_wdata  out  XLEN  value for mcause
- mstatus_trap  out  1  MPIE<=MIE, MIE<=0
- mstatus_mret  out  1  MIE<=MPIE, MPIE<=1
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; counter and captured PC/cause registers cleared; all outputs 0.
- take = mstatus_mie & ((meip&meie)|(mtip&mtie)) & ~StallD.
- Priority: external (cause 11) over timer (cause 7). mcause_wdata = {1'b1, 26'b0, code[4:0]}, interrupt bit 31 set.
- States: IDLE, FLUSH, DRAIN, TRAP, RET.
- IDLE:
  - mret_E=1 → RET. MRET wins over a simultaneous interrupt.
  - else take=1 → FLUSH. Latch cause; latch epc = pcd_valid ? PCD : PCF.
  - Outputs 0.
- FLUSH (1 cycle): Int_flush=1, stall_F=1. Load counter=DRAIN_CYCLES-1 → DRAIN.
- DRAIN: stall_F=1, Int_flush=1 every cycle, so no new instruction enters EX.
  - Counter decrements each cycle.
  - At counter==0 → TRAP.
- TRAP (1 cycle):
  - mepc_we=1, mepc_wdata=latched epc.
  - mcause_we=1, mstatus_trap=1.
  - pc_redirect=1, pc_target = {mtvec[XLEN-1:2],2'b00}, Int_flush=1.
  - → IDLE.
- RET (1 cycle): pc_redirect=1, pc_target=mepc_in, Int_flush=1, mstatus_mret=1 → IDLE.
- Latency: interrupt sampled in IDLE to redirect = DRAIN_CYCLES+2 cycles. MRET = 1 cycle.
- Interrupt pending deasserting after FLUSH: sequence still completes with latched cause. The trap is committed once FLUSH is entered.
- New interrupts and mret_E are ignored while busy=1.
- StallD=1 defers taking an interrupt; the controller stays in IDLE.
- Reset mid-sequence: immediate return to IDLE. No CSR strobes are emitted.
- busy = (state != IDLE).
- All outputs are registered-state decodes, with no combinational path from inputs. Exception: none.

Optional Feature:
- Macro TRAP_VECTORED_EN.
- Defined: when mtvec[1:0]==2'b01, TRAP uses pc_target = {mtvec[XLEN-1:2],2'b00} + (code<<2). The addition wraps modulo 2^XLEN.
- Undefined: mtvec[1:0] is ignored and the direct base is always used.
- RET behaviour is identical in both builds.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=0, FLUSH=1, DRAIN=2, TRAP=3, RET=4 (3 bits);
  - cause codes CAUSE_MEI=11, CAUSE_MTI=7;
  - MCAUSE_INT_BIT=31;
  - MTVEC_MODE_VEC=2'b01.
- One sub-module, trap_cause_sel: combinational priority encoder (meip/meie/mtip/mtie → valid, code[4:0]).

Test Plan:
- Reset: hold rst=0 mid-DRAIN, release → all outputs 0, busy=0, state IDLE, no mepc_we pulse.
- Timer IRQ: mstatus_mie=1, mtie=1, mtip=1, PCD=0x0000_0040, pcd_valid=1, mtvec=0x0000_0100, DRAIN_CYCLES=3.
  - Required: Int_flush for cycles 1–4 and on the TRAP cycle; TRAP 5 cycles after sample.
  - TRAP: mepc_wdata=0x40, mcause_wdata=0x8000_0007, pc_target=0x100.
- Simultaneous meip and mtip with meie=mtie=1 → mcause_wdata=0x8000_000B. With TRAP_VECTORED_EN and mtvec=0x101 → pc_target=0x12C.
- Collision and stall:
  - mret_E=1 in the same cycle as a pending IRQ → RET. pc_target=mepc_in=0x44, mstatus_mret=1; no mcause_we.
  - The IRQ is then taken from IDLE on a later cycle.
- StallD=1 for 4 cycles with pending IRQ → stays IDLE, busy=0. Enters FLUSH the cycle after StallD drops.
- pcd_valid=0, PCF=0x80, then mtip drops during DRAIN → trap completes with mepc_wdata=0x80, mcause=0x8000_0007.
